// File: rtl/alu_pkg.sv
// ALU opcode type and opcode constants shared by the ALU and its users.
package alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_AND   = 4'b0000;
   localparam alu_op_t ALU_OR    = 4'b0001;
   localparam alu_op_t ALU_ADD   = 4'b0010;
   localparam alu_op_t ALU_SUB   = 4'b0110;
   localparam alu_op_t ALU_PASSB = 4'b0111;
   localparam alu_op_t ALU_NOR   = 4'b1100;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU. Unknown opcodes pass operand B through.
// ADD/SUB wrap modulo 2^N; zero flags an all-zero result.
module alu
   import alu_pkg::*;
#(
   parameter int N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  alu_op_t      alu_control,
   output logic [N-1:0] result,
   output logic         zero
);

   // Opcode decode and result select
   always_comb begin
      result = b;
      case (alu_control)
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_PASSB: result = b;
         ALU_NOR:   result = ~(a | b);
         default:   result = b;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first eligible
// requester found searching upward from (last+1) mod NREQ, with wrap.
// Nothing is granted while advance is low.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [LW-1:0]   last,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [LW-1:0]   grant_idx,
   output logic            grant_any
);

   // Rotating priority search starting just after the previous winner
   always_comb begin
      int unsigned idx;
      logic [LW-1:0] sel;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = (32'(last) + off) % NREQ;
         sel = idx[LW-1:0];
         if (advance && !grant_any && eligible[sel]) begin
            grant[sel] = 1'b1;
            grant_idx  = sel;
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ valid/ready requesters with round-robin
// arbitration and a registered response slot per requester.
// Optional build macro ALU_ARB_PERF_EN adds grant/conflict counters.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter  int N    = 64,
   parameter  int NREQ = 2,
   localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*4-1:0] req_op,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [NREQ*N-1:0] resp_result,
   output logic [NREQ-1:0]   resp_zero
`ifdef ALU_ARB_PERF_EN
   ,
   input  logic              perf_clear,
   output logic [NREQ*32-1:0] perf_grants,
   output logic [31:0]       perf_conflicts
`endif
);

   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   grant;
   logic [LW-1:0]     grant_idx;
   logic              grant_any;

   logic [LW-1:0]     last_q, last_d;
   logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
   logic [NREQ*N-1:0] resp_result_q, resp_result_d;
   logic [NREQ-1:0]   resp_zero_q, resp_zero_d;

   logic [N-1:0]      alu_a, alu_b, alu_result;
   alu_op_t           alu_op;
   logic              alu_zero_unused;

   // A slot draining this cycle may be refilled in the same cycle
   always_comb begin
      eligible = req_valid & (~resp_valid_q | resp_ready);
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .eligible  (eligible),
      .last      (last_q),
      .advance   (1'b1),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   // Steer the winner's operands and opcode onto the shared ALU
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_AND;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            alu_a  = req_a[i*N +: N];
            alu_b  = req_b[i*N +: N];
            alu_op = alu_op_t'(req_op[i*4 +: 4]);
         end
      end
   end

   alu #(.N(N)) u_alu (
      .a           (alu_a),
      .b           (alu_b),
      .alu_control (alu_op),
      .result      (alu_result),
      .zero        (alu_zero_unused)
   );

   // Next-state for response slots and round-robin pointer
   always_comb begin
      resp_valid_d  = resp_valid_q;
      resp_result_d = resp_result_q;
      resp_zero_d   = resp_zero_q;
      last_d        = grant_any ? grant_idx : last_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            resp_valid_d[i]         = 1'b1;
            resp_result_d[i*N +: N] = alu_result;
            resp_zero_d[i]          = (alu_result == '0);
         end else if (resp_valid_q[i] && resp_ready[i]) begin
            resp_valid_d[i] = 1'b0;
         end
      end
   end

   // Slot and pointer registers; reset empties every slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q        <= LW'(NREQ - 1);
         resp_valid_q  <= '0;
         resp_result_q <= '0;
         resp_zero_q   <= '0;
      end else begin
         last_q        <= last_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_zero_q   <= resp_zero_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_zero   = resp_zero_q;

`ifdef ALU_ARB_PERF_EN
   logic [NREQ*32-1:0] perf_grants_q, perf_grants_d;
   logic [31:0]        perf_conflicts_q, perf_conflicts_d;

   // Saturating counters: grants per requester and contended cycles
   always_comb begin
      perf_grants_d    = perf_grants_q;
      perf_conflicts_d = perf_conflicts_q;
      if (perf_clear) begin
         perf_grants_d    = '0;
         perf_conflicts_d = '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i] && (perf_grants_q[i*32 +: 32] != '1)) begin
               perf_grants_d[i*32 +: 32] = perf_grants_q[i*32 +: 32] + 32'd1;
            end
         end
         if (($countones(eligible) >= 2) && (perf_conflicts_q != '1)) begin
            perf_conflicts_d = perf_conflicts_q + 32'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_grants_q    <= '0;
         perf_conflicts_q <= '0;
      end else begin
         perf_grants_q    <= perf_grants_d;
         perf_conflicts_q <= perf_conflicts_d;
      end
   end

   assign perf_grants    = perf_grants_q;
   assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N=64, NREQ=2).
module tb_alu_arbiter;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [7:0]   req_op;
   logic [1:0]   resp_valid;
   logic [1:0]   resp_ready;
   logic [127:0] resp_result;
   logic [1:0]   resp_zero;
`ifdef ALU_ARB_PERF_EN
   logic         perf_clear;
   logic [63:0]  perf_grants;
   logic [31:0]  perf_conflicts;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(64), .NREQ(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_op      (req_op),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_zero   (resp_zero)
`ifdef ALU_ARB_PERF_EN
      ,
      .perf_clear     (perf_clear),
      .perf_grants    (perf_grants),
      .perf_conflicts (perf_conflicts)
`endif
   );

   task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op);
      req_a[i*64 +: 64] = a;
      req_b[i*64 +: 64] = b;
      req_op[i*4 +: 4]  = op;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n    = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      set_req(0, 64'd1, 64'd2, 4'b0010);
      set_req(1, 64'd3, 64'd4, 4'b0010);
      tick();
      vectors++;
      if (resp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_valid: got %b want 00", resp_valid);
      end
      vectors++;
      if (resp_result !== 128'd0) begin
         miscompares++;
         $display("FAIL reset_result: got %h want 0", resp_result);
      end
      vectors++;
      if (resp_zero !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_zero: got %b want 00", resp_zero);
      end
      reset_n = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_first_winner: got %b want 01", req_ready);
      end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
   endtask

   task automatic test_single_add();
      apply_reset();
      set_req(0, 64'd5, 64'd7, 4'b0010);
      req_valid = 2'b01;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL add_ready: got %b want 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      vectors++;
      if (resp_valid !== 2'b01) begin
         miscompares++;
         $display("FAIL add_valid: got %b want 01", resp_valid);
      end
      vectors++;
      if (resp_result[63:0] !== 64'd12 || resp_zero[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL add_result: got %h z=%b want 12 z=0", resp_result[63:0], resp_zero[0]);
      end
      resp_ready = 2'b01;
      tick();
      vectors++;
      if (resp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL add_drain: got %b want 00", resp_valid);
      end
      vectors++;
      if (resp_result[63:0] !== 64'd12) begin
         miscompares++;
         $display("FAIL add_hold_after_drain: got %h want 12", resp_result[63:0]);
      end
      resp_ready = 2'b00;
   endtask

   task automatic test_alternate();
      int          win [6] = '{0, 1, 0, 1, 0, 1};
      logic [63:0] ta  [6] = '{64'd3, 64'd0, 64'hF0, 64'hF0, 64'h1234, 64'd9};
      logic [63:0] tb  [6] = '{64'd3, 64'd0, 64'h3C, 64'h0F, 64'h55, 64'hAB};
      logic [3:0]  top [6] = '{4'b0110, 4'b1100, 4'b0000, 4'b0001, 4'b1010, 4'b0111};
      logic [63:0] ter [6] = '{64'd0, ONES, 64'h30, 64'hFF, 64'h55, 64'hAB};
      logic        tez [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_reset();
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      for (int k = 0; k < 6; k++) begin
         set_req(0, ta[k], tb[k], top[k]);
         set_req(1, ta[k], tb[k], top[k]);
         #1;
         vectors++;
         if (req_ready !== (2'b01 << win[k])) begin
            miscompares++;
            $display("FAIL alt_grant[%0d]: got %b want one-hot %0d", k, req_ready, win[k]);
         end
         tick();
         vectors++;
         if (resp_valid[win[k]] !== 1'b1 || resp_result[win[k]*64 +: 64] !== ter[k] ||
             resp_zero[win[k]] !== tez[k]) begin
            miscompares++;
            $display("FAIL alt_result[%0d]: got v=%b r=%h z=%b want v=1 r=%h z=%b", k,
                     resp_valid[win[k]], resp_result[win[k]*64 +: 64], resp_zero[win[k]],
                     ter[k], tez[k]);
         end
      end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
   endtask

   task automatic test_backpressure();
      apply_reset();
      set_req(0, 64'd1, 64'd1, 4'b0010);
      req_valid = 2'b01;
      tick();
      set_req(0, 64'd5, 64'd5, 4'b0010);
      req_valid  = 2'b11;
      resp_ready = 2'b10;
      for (int k = 0; k < 4; k++) begin
         set_req(1, 64'(k), 64'd1, 4'b0010);
         #1;
         vectors++;
         if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_grant[%0d]: got %b want 10", k, req_ready);
         end
         tick();
         vectors++;
         if (resp_valid !== 2'b11 || resp_result[63:0] !== 64'd2) begin
            miscompares++;
            $display("FAIL bp_slot0_hold[%0d]: got v=%b r=%h want v=11 r=2", k, resp_valid,
                     resp_result[63:0]);
         end
         vectors++;
         if (resp_result[127:64] !== 64'(k + 1)) begin
            miscompares++;
            $display("FAIL bp_slot1[%0d]: got %h want %0d", k, resp_result[127:64], k + 1);
         end
      end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
   endtask

   task automatic test_boundary();
      apply_reset();
      req_valid  = 2'b10;
      resp_ready = 2'b10;
      set_req(1, 64'd0, 64'd1, 4'b0110);
      #1;
      vectors++;
      if (req_ready !== 2'b10) begin
         miscompares++;
         $display("FAIL sub_wrap_ready: got %b want 10", req_ready);
      end
      tick();
      vectors++;
      if (resp_result[127:64] !== ONES || resp_zero[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL sub_wrap: got %h z=%b want all-ones z=0", resp_result[127:64], resp_zero[1]);
      end
      set_req(1, ONES, 64'd1, 4'b0010);
      #1;
      vectors++;
      if (req_ready !== 2'b10) begin
         miscompares++;
         $display("FAIL add_wrap_ready: got %b want 10", req_ready);
      end
      tick();
      vectors++;
      if (resp_valid[1] !== 1'b1 || resp_result[127:64] !== 64'd0 || resp_zero[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL add_wrap: got v=%b r=%h z=%b want v=1 r=0 z=1", resp_valid[1],
                  resp_result[127:64], resp_zero[1]);
      end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
   endtask

   task automatic test_drain_refill();
      apply_reset();
      set_req(0, 64'd2, 64'd3, 4'b0010);
      req_valid = 2'b01;
      tick();
      vectors++;
      if (resp_valid[0] !== 1'b1 || resp_result[63:0] !== 64'd5) begin
         miscompares++;
         $display("FAIL refill_first: got v=%b r=%h want v=1 r=5", resp_valid[0], resp_result[63:0]);
      end
      set_req(0, 64'd10, 64'd20, 4'b0010);
      resp_ready = 2'b01;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL refill_ready: got %b want 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      vectors++;
      if (resp_valid[0] !== 1'b1 || resp_result[63:0] !== 64'd30) begin
         miscompares++;
         $display("FAIL refill_data: got v=%b r=%h want v=1 r=30", resp_valid[0], resp_result[63:0]);
      end
      tick();
      vectors++;
      if (resp_valid[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL refill_drain: got %b want 0", resp_valid[0]);
      end
      resp_ready = 2'b00;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_req(0, 64'd4, 64'd4, 4'b0010);
      set_req(1, 64'd6, 64'd6, 4'b0010);
      req_valid = 2'b11;
      tick();
      tick();
      vectors++;
      if (resp_valid !== 2'b11) begin
         miscompares++;
         $display("FAIL mid_prefill: got %b want 11", resp_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (resp_valid !== 2'b00 || resp_result !== 128'd0 || resp_zero !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_reset_async: got v=%b r=%h z=%b want all 0", resp_valid, resp_result,
                  resp_zero);
      end
      reset_n    = 1'b1;
      resp_ready = 2'b11;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL mid_first_winner: got %b want 01", req_ready);
      end
      tick();
      vectors++;
      if (resp_valid !== 2'b01 || resp_result[63:0] !== 64'd8) begin
         miscompares++;
         $display("FAIL mid_after_release: got v=%b r=%h want v=01 r=8", resp_valid,
                  resp_result[63:0]);
      end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
   endtask

`ifdef ALU_ARB_PERF_EN
   task automatic test_perf();
      perf_clear = 1'b0;
      apply_reset();
      vectors++;
      if (perf_conflicts !== 32'd0 || perf_grants !== 64'd0) begin
         miscompares++;
         $display("FAIL perf_reset: got c=%0d g=%h want 0", perf_conflicts, perf_grants);
      end
      set_req(0, 64'd1, 64'd2, 4'b0010);
      set_req(1, 64'd3, 64'd4, 4'b0010);
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      for (int k = 0; k < 10; k++) tick();
      req_valid = 2'b00;
      #1;
      vectors++;
      if (perf_conflicts !== 32'd10) begin
         miscompares++;
         $display("FAIL perf_conflicts: got %0d want 10", perf_conflicts);
      end
      vectors++;
      if (perf_grants[31:0] !== 32'd5 || perf_grants[63:32] !== 32'd5) begin
         miscompares++;
         $display("FAIL perf_grants: got %0d/%0d want 5/5", perf_grants[31:0], perf_grants[63:32]);
      end
      perf_clear = 1'b1;
      tick();
      perf_clear = 1'b0;
      vectors++;
      if (perf_conflicts !== 32'd0 || perf_grants !== 64'd0) begin
         miscompares++;
         $display("FAIL perf_clear: got c=%0d g=%h want 0", perf_conflicts, perf_grants);
      end
      resp_ready = 2'b00;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
`ifdef ALU_ARB_PERF_EN
      perf_clear = 1'b0;
`endif
      #2;
      test_reset();
      test_single_add();
      test_alternate();
      test_backpressure();
      test_boundary();
      test_drain_refill();
      test_reset_mid();
`ifdef ALU_ARB_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
